// File: rtl/morse_round_sequencer.sv
// Round controller feeding the Morse display decoder: LFSR symbol pick, per-round countdown, saturating score.
// Optional macro MORSE_SEQ_HEX_EN passes the raw hex symbol 0..F; when undefined, symbols are folded to digits 0..9.
module morse_round_sequencer #(
    parameter int         CLK_TICKS  = 50_000_000,
    parameter int         ROUND_SECS = 10,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       logout,
    input  logic       answer_valid,
    input  logic       answer_correct,
    output logic [3:0] number,
    output logic       timeout,
    output logic       round_active,
    output logic [3:0] secs_left,
    output logic [7:0] score,
    output logic       round_done
);

    localparam int            PW        = (CLK_TICKS > 2) ? $clog2(CLK_TICKS) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(CLK_TICKS - 1);
    localparam logic [7:0]    SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [3:0]    SECS_INIT = 4'(ROUND_SECS);

    typedef enum logic [1:0] {IDLE, RUN, TIMEOUT, RESULT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [3:0]    number_q, number_d;
    logic [3:0]    secs_q, secs_d;
    logic [7:0]    score_q, score_d;
    logic          timeout_q, timeout_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          tick;

    function automatic logic [3:0] map_symbol(input logic [3:0] v);
`ifdef MORSE_SEQ_HEX_EN
        return v;
`else
        return (v > 4'd9) ? (v - 4'd6) : v;
`endif
    endfunction

    assign tick = (presc_q == TICK_LAST);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        number_d  = number_q;
        secs_d    = secs_q;
        score_d   = score_q;
        timeout_d = timeout_q;
        active_d  = active_q;
        done_d    = 1'b0;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (logout) begin
            state_d   = IDLE;
            presc_d   = '0;
            score_d   = 8'h00;
            timeout_d = 1'b0;
            active_d  = 1'b0;
            secs_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE, TIMEOUT: begin
                    if (start) begin
                        state_d   = RUN;
                        number_d  = map_symbol(lfsr_q[3:0]);
                        secs_d    = SECS_INIT;
                        presc_d   = '0;
                        timeout_d = 1'b0;
                        active_d  = 1'b1;
                    end
                end
                RUN: begin
                    // An answer landing on the final tick takes precedence over the timeout.
                    if (answer_valid) begin
                        state_d  = RESULT;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        if (answer_correct && (score_q != 8'hFF)) begin
                            score_d = score_q + 8'd1;
                        end
                    end else if (tick) begin
                        presc_d = '0;
                        if (secs_q > 4'd1) begin
                            secs_d = secs_q - 4'd1;
                        end else begin
                            secs_d    = 4'd0;
                            state_d   = TIMEOUT;
                            timeout_d = 1'b1;
                            active_d  = 1'b0;
                            done_d    = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                RESULT: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            lfsr_q    <= SEED_EFF;
            number_q  <= 4'd0;
            secs_q    <= 4'd0;
            score_q   <= 8'h00;
            timeout_q <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            lfsr_q    <= lfsr_d;
            number_q  <= number_d;
            secs_q    <= secs_d;
            score_q   <= score_d;
            timeout_q <= timeout_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign number       = number_q;
    assign timeout      = timeout_q;
    assign round_active = active_q;
    assign secs_left    = secs_q;
    assign score        = score_q;
    assign round_done   = done_q;

endmodule

// File: tb/tb_morse_round_sequencer.sv
// Scoreboard bench for morse_round_sequencer: a cycle-count reference model queues expected outputs, a monitor compares them.
module tb_morse_round_sequencer;

    localparam int         CT   = 4;
    localparam int         RS   = 3;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef MORSE_SEQ_HEX_EN
    localparam int T6_EXP = 12;
`else
    localparam int T6_EXP = 6;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, logout = 1'b0, answer_valid = 1'b0, answer_correct = 1'b0;
    logic [3:0] number, secs_left, number2, secs2;
    logic       timeout, round_active, round_done, to2, ra2, rd2;
    logic [7:0] score, sc2;

    morse_round_sequencer #(.CLK_TICKS(CT), .ROUND_SECS(RS), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .logout(logout),
        .answer_valid(answer_valid), .answer_correct(answer_correct),
        .number(number), .timeout(timeout), .round_active(round_active),
        .secs_left(secs_left), .score(score), .round_done(round_done)
    );

    morse_round_sequencer #(.CLK_TICKS(CT), .ROUND_SECS(RS), .LFSR_SEED(8'hAC)) dut_ac (
        .clk(clk), .rst(rst), .start(start), .logout(logout),
        .answer_valid(answer_valid), .answer_correct(answer_correct),
        .number(number2), .timeout(to2), .round_active(ra2),
        .secs_left(secs2), .score(sc2), .round_done(rd2)
    );

    typedef struct {
        int number;
        int timeout;
        int active;
        int secs;
        int score;
        int done;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: round progress is tracked as elapsed cycles since the round began.
    bit         m_in_round = 0, m_timed_out = 0, m_result = 0;
    int         m_elapsed = 0, m_score = 0, m_secs = 0, m_number = 0;
    logic [7:0] m_lfsr = SEED;

    function automatic int sym(input int v);
`ifdef MORSE_SEQ_HEX_EN
        return v;
`else
        return (v >= 10) ? v - 6 : v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit lo, input bit av, input bit ac);
        exp_t e;
        bit   done;
        done = 0;
        rst = r; start = s; logout = lo; answer_valid = av; answer_correct = ac;
        if (r) begin
            m_in_round = 0; m_timed_out = 0; m_result = 0;
            m_score = 0; m_secs = 0; m_number = 0; m_lfsr = SEED;
        end else begin
            if (lo) begin
                m_in_round = 0; m_timed_out = 0; m_result = 0;
                m_score = 0; m_secs = 0;
            end else if (m_in_round) begin
                m_elapsed++;
                if (av) begin
                    m_in_round = 0; m_result = 1; done = 1;
                    if (ac && m_score < 255) m_score++;
                end else if (m_elapsed == RS * CT) begin
                    m_in_round = 0; m_timed_out = 1; done = 1; m_secs = 0;
                end else begin
                    m_secs = RS - m_elapsed / CT;
                end
            end else if (m_result) begin
                m_result = 0;
            end else if (s) begin
                m_in_round = 1; m_timed_out = 0; m_elapsed = 0;
                m_number = sym(int'(m_lfsr[3:0])); m_secs = RS;
            end
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
        e.number = m_number; e.timeout = int'(m_timed_out); e.active = int'(m_in_round);
        e.secs = m_secs; e.score = m_score; e.done = int'(done);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            chk("number",       int'(number),       me.number);
            chk("timeout",      int'(timeout),      me.timeout);
            chk("round_active", int'(round_active), me.active);
            chk("secs_left",    int'(secs_left),    me.secs);
            chk("score",        int'(score),        me.score);
            chk("round_done",   int'(round_done),   me.done);
        end
    end

    initial begin
        // Reset, then start in the first cycle after it
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("number_first_round", int'(number), 5);
        chk("number_seed_ac", int'(number2), T6_EXP);
        // Let the round time out and hold
        for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0);
        // Restart from timeout, correct answer at secs_left=2
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Wrong answer on the final-tick cycle
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Logout together with start
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 17) == 0,
                 $urandom_range(0, 1) == 1);
        end
        // Fast correct rounds to drive the score into saturation
        for (int i = 0; i < 270; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 300; i++) begin
            step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
